seq_mult_ctrl: RTL and testbench



---
 rtl/seq_mult_ctrl_if.sv | 44 ++++
 rtl/seq_mult_ctrl.sv | 132 +++++++++++++
 tb/tb_seq_mult_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/seq_mult_ctrl_if.sv
// Handshake and operand/result bundle for the seq_mult_ctrl shift-and-add multiplier.
// Optional macro SEQ_MULT_SIGNED_EN adds the signed_in operand qualifier.
interface seq_mult_ctrl_if #(
    parameter int WIDTH = 4
);
    logic                 start;
`ifdef SEQ_MULT_SIGNED_EN
    logic                 signed_in;
`endif
    logic [WIDTH-1:0]     a_in;
    logic [WIDTH-1:0]     b_in;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   p_out;
    logic                 zero;

    // Requester side: issues operands and start, observes status and product
    modport master (
        output start,
`ifdef SEQ_MULT_SIGNED_EN
        output signed_in,
`endif
        output a_in,
        output b_in,
        input  busy,
        input  done,
        input  p_out,
        input  zero
    );

    // Multiplier side
    modport slave (
        input  start,
`ifdef SEQ_MULT_SIGNED_EN
        input  signed_in,
`endif
        input  a_in,
        input  b_in,
        output busy,
        output done,
        output p_out,
        output zero
    );
endinterface

// File: rtl/seq_mult_ctrl.sv
// Sequential shift-and-add multiplier with an IDLE/CALC/DONE controller.
// The multiplicand shifts left, the multiplier shifts right, and iteration
// stops as soon as the multiplier register is empty, so short multipliers
// finish early. Optional macro SEQ_MULT_SIGNED_EN enables two's complement
// operands by multiplying magnitudes and negating the product at the end.
module seq_mult_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                clr,
    seq_mult_ctrl_if.slave      bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic [2*WIDTH-1:0]   p_out_q, p_out_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [2*WIDTH-1:0]   result;

`ifdef SEQ_MULT_SIGNED_EN
    logic                 neg_q, neg_d;
    logic                 neg_req;

    // Convert signed operands to unsigned magnitudes; the most negative value maps onto its own bit pattern
    always_comb begin
        a_mag   = (bus.signed_in && bus.a_in[WIDTH-1]) ? -bus.a_in : bus.a_in;
        b_mag   = (bus.signed_in && bus.b_in[WIDTH-1]) ? -bus.b_in : bus.b_in;
        neg_req = bus.signed_in && (bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1]);
        result  = (neg_q && (p_q != '0)) ? -p_q : p_q;
    end
`else
    // Unsigned build: operands are already magnitudes and the product is used as-is
    always_comb begin
        a_mag  = bus.a_in;
        b_mag  = bus.b_in;
        result = p_q;
    end
`endif

    // Controller and datapath next-state: load on start, one shift/add per CALC cycle, publish on exit
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        p_out_d = p_out_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
        neg_d   = neg_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = {{WIDTH{1'b0}}, a_mag};
                    b_d     = b_mag;
                    p_d     = '0;
                    busy_d  = 1'b1;
                    state_d = CALC;
`ifdef SEQ_MULT_SIGNED_EN
                    neg_d   = neg_req;
`endif
                end
            end
            CALC: begin
                if (b_q == '0) begin
                    p_out_d = result;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    if (b_q[0]) begin
                        p_d = p_q + a_q;
                    end
                    a_d = a_q << 1;
                    b_d = b_q >> 1;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; clr wins over any request in the same cycle and aborts silently
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            p_out_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
            neg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            p_out_q <= p_out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SEQ_MULT_SIGNED_EN
            neg_q   <= neg_d;
`endif
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.p_out = p_out_q;
    assign bus.zero  = (b_q == '0);

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed bench for seq_mult_ctrl: a WIDTH=4 and a WIDTH=8 instance share clock and clear.
module tb_seq_mult_ctrl;

    logic clk = 1'b0;
    logic clr;

    always #5 clk = ~clk;

    seq_mult_ctrl_if #(.WIDTH(4)) bus4();
    seq_mult_ctrl_if #(.WIDTH(8)) bus8();

    seq_mult_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .clr(clr), .bus(bus4));
    seq_mult_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .clr(clr), .bus(bus8));

    int checkCount = 0;
    int failCount  = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic getDone(input bit sel);
        return sel ? bus8.done : bus4.done;
    endfunction

    function automatic logic getBusy(input bit sel);
        return sel ? bus8.busy : bus4.busy;
    endfunction

    function automatic logic getZero(input bit sel);
        return sel ? bus8.zero : bus4.zero;
    endfunction

    function automatic logic [31:0] getP(input bit sel);
        return sel ? {16'b0, bus8.p_out} : {24'b0, bus4.p_out};
    endfunction

    task automatic driveStart(input bit sel, input logic s, input logic [7:0] a, input logic [7:0] b, input logic sgn);
        if (sel) begin
            bus8.start = s;
            bus8.a_in  = a;
            bus8.b_in  = b;
`ifdef SEQ_MULT_SIGNED_EN
            bus8.signed_in = sgn;
`endif
        end else begin
            bus4.start = s;
            bus4.a_in  = a[3:0];
            bus4.b_in  = b[3:0];
`ifdef SEQ_MULT_SIGNED_EN
            bus4.signed_in = sgn;
`endif
        end
    endtask

    // Called #1 after an edge with the DUT idle; returns #1 after the edge that ends the DONE cycle
    task automatic applyStimulus(input string tag, input bit sel, input logic [7:0] a, input logic [7:0] b,
                                 input logic sgn, input int expLat, input logic [31:0] expP,
                                 input bit pokeBusy, input logic [31:0] prevP);
        int edges;
        bit seen;
        int extraDone;
        driveStart(sel, 1'b1, a, b, sgn);
        @(posedge clk); #1;
        if (pokeBusy) driveStart(sel, 1'b1, 8'd1, 8'd1, 1'b0);
        else          driveStart(sel, 1'b0, 8'd0, 8'd0, 1'b0);
        checkOutput({tag, "_busy_first"}, {31'b0, getBusy(sel)}, 32'd1);
        checkOutput({tag, "_p_hold"}, getP(sel), prevP);
        edges = 0;
        seen  = 0;
        while (!seen && edges < 20) begin
            @(posedge clk); #1;
            edges++;
            if (pokeBusy && edges == 1) driveStart(sel, 1'b0, 8'd0, 8'd0, 1'b0);
            if (getDone(sel)) seen = 1;
        end
        checkOutput({tag, "_latency"}, edges, expLat);
        checkOutput({tag, "_p"}, getP(sel), expP);
        checkOutput({tag, "_busy_done"}, {31'b0, getBusy(sel)}, 32'd1);
        @(posedge clk); #1;
        checkOutput({tag, "_done_pulse"}, {31'b0, getDone(sel)}, 32'd0);
        checkOutput({tag, "_busy_idle"}, {31'b0, getBusy(sel)}, 32'd0);
        checkOutput({tag, "_p_after"}, getP(sel), expP);
        if (pokeBusy) begin
            extraDone = 0;
            for (int i = 0; i < 6; i++) begin
                @(posedge clk); #1;
                if (getDone(sel)) extraDone++;
            end
            checkOutput({tag, "_extra_done"}, extraDone, 0);
            checkOutput({tag, "_p_final"}, getP(sel), expP);
        end
    endtask

    initial begin
        int extraDone;
        clr = 1'b1;
        driveStart(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
        driveStart(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst4_busy", {31'b0, bus4.busy}, 32'd0);
        checkOutput("rst4_done", {31'b0, bus4.done}, 32'd0);
        checkOutput("rst4_p",    getP(1'b0), 32'd0);
        checkOutput("rst4_zero", {31'b0, bus4.zero}, 32'd1);
        checkOutput("rst8_busy", {31'b0, bus8.busy}, 32'd0);
        checkOutput("rst8_p",    getP(1'b1), 32'd0);
        clr = 1'b0;

        applyStimulus("t1_3x2",   1'b0, 8'd3,  8'd2,  1'b0, 3, 32'd6,   1'b0, 32'd0);
        applyStimulus("t2_9x0",   1'b0, 8'd9,  8'd0,  1'b0, 1, 32'd0,   1'b0, 32'd6);
        applyStimulus("t2_15x15", 1'b0, 8'd15, 8'd15, 1'b0, 5, 32'hE1,  1'b0, 32'd0);
        applyStimulus("t3_5x7",   1'b0, 8'd5,  8'd7,  1'b0, 4, 32'd35,  1'b1, 32'hE1);

        // Abort with clr on the second CALC edge
        driveStart(1'b0, 1'b1, 8'd15, 8'd15, 1'b0);
        @(posedge clk); #1;
        driveStart(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        checkOutput("t4_abort_busy", {31'b0, bus4.busy}, 32'd0);
        checkOutput("t4_abort_done", {31'b0, bus4.done}, 32'd0);
        checkOutput("t4_abort_p",    getP(1'b0), 32'd0);
        checkOutput("t4_abort_zero", {31'b0, getZero(1'b0)}, 32'd1);
        extraDone = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus4.done) extraDone++;
        end
        checkOutput("t4_abort_nodone", extraDone, 0);
        applyStimulus("t4_2x3",   1'b0, 8'd2,  8'd3,  1'b0, 3, 32'd6,   1'b0, 32'd0);

        applyStimulus("t5_255x255", 1'b1, 8'd255, 8'd255, 1'b0, 9, 32'hFE01, 1'b0, 32'd0);
        applyStimulus("t5_12x10",   1'b1, 8'd12,  8'd10,  1'b0, 5, 32'd120,  1'b0, 32'hFE01);

`ifdef SEQ_MULT_SIGNED_EN
        applyStimulus("t6_m8x7",   1'b0, 8'h8, 8'h7, 1'b1, 4, 32'hC8,  1'b0, 32'd6);
        applyStimulus("t6_m3xm3",  1'b0, 8'hD, 8'hD, 1'b1, 3, 32'd9,   1'b0, 32'hC8);
        applyStimulus("t6_u8x7",   1'b0, 8'h8, 8'h7, 1'b0, 4, 32'd56,  1'b0, 32'd9);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
